mem_port_arbiter: RTL and testbench

Sequences the single byte-wide RAM port of the CPU and shares it between the instruction-fetch stage and the load/store (MEM) stage. Each request is serialised into 1/2/4 byte cycles; read bytes are assembled into a little-endian word and sign- or zero-extended per funct3. Busy status is exported to the stall controller, so the fetch and decode stages hold while the port is occupied. Sits between `stage_if`/`stage_mem` and the top-level RAM pins.

---
 rtl/mem_port_arbiter_pkg.sv | 35 +++
 rtl/mem_port_arbiter_byte_assembler.sv | 20 ++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM port arbiter: FSM states,
// owner codes, load/store funct3 encodings and the byte-count decode.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_MEM  = 2'd2
  } owner_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic [2:0] funct3_nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_byte_assembler.sv
// Combinational sign/zero extension of 1, 2 or 4 little-endian captured bytes.
module byte_assembler #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_bytes,
  input  logic [2:0]        i_nbytes,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_word
);

  always_comb begin
    o_word = i_bytes;
    case (i_nbytes)
      3'd1:    o_word = {{(DATA_W-8){i_sign & i_bytes[7]}}, i_bytes[7:0]};
      3'd2:    o_word = {{(DATA_W-16){i_sign & i_bytes[15]}}, i_bytes[15:0]};
      default: o_word = i_bytes;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store,
// serialising each request into 1/2/4 byte cycles (MEM has priority).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rdy,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_cancel,
  output logic              o_if_done,
  output logic [DATA_W-1:0] o_if_inst,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [2:0]        i_mem_funct3,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_mem_done,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic              o_ram_wr,
  output logic [7:0]        o_ram_dout,
  input  logic [7:0]        i_ram_din,
  output logic              o_busy
);

  state_t              r_state, w_state_nxt;
  owner_t              r_owner;
  logic [2:0]          r_cnt;
  logic [2:0]          r_n;
  logic                r_sign;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_data;

  logic                w_accept_mem;
  logic                w_accept_if;
  logic                w_if_abort;
  logic [1:0]          w_cap_idx;
  logic [ADDR_W-1:0]   w_cur_addr;
  logic [DATA_W-1:0]   w_word;

  assign w_accept_mem = (r_state == ST_IDLE) && i_mem_req;
  assign w_accept_if  = (r_state == ST_IDLE) && !i_mem_req && i_if_req && !i_if_cancel;
  assign w_if_abort   = i_rdy && i_if_cancel && (r_owner == OWNER_IF) &&
                        ((r_state == ST_READ) || (r_state == ST_FINISH));
  // Byte k arrives one cycle after its address, so capture lags the counter by one.
  assign w_cap_idx    = r_cnt[1:0] - 2'd1;
  assign w_cur_addr   = r_addr + ADDR_W'(r_cnt);

  byte_assembler #(.DATA_W(DATA_W)) u_byte_assembler (
    .i_bytes  (r_data),
    .i_nbytes (r_n),
    .i_sign   (r_sign),
    .o_word   (w_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rdy && w_accept_mem)     w_state_nxt = i_mem_we ? ST_WRITE : ST_READ;
        else if (i_rdy && w_accept_if) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if (w_if_abort)                   w_state_nxt = ST_IDLE;
        else if (i_rdy && (r_cnt == r_n)) w_state_nxt = ST_FINISH;
      end
      ST_WRITE: begin
        if (i_rdy && (r_cnt == r_n - 3'd1)) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        if (i_rdy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ram_a     = '0;
    o_ram_wr    = 1'b0;
    o_ram_dout  = '0;
    o_mem_done  = 1'b0;
    o_mem_rdata = '0;
    o_if_done   = 1'b0;
    o_if_inst   = '0;
    o_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_READ: begin
        if (r_cnt < r_n) o_ram_a = w_cur_addr;
      end
      ST_WRITE: begin
        o_ram_a    = w_cur_addr;
        o_ram_wr   = i_rdy;
        o_ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
      end
      ST_FINISH: begin
        if (r_owner == OWNER_MEM) begin
          o_mem_done  = i_rdy;
          o_mem_rdata = w_word;
        end else if (r_owner == OWNER_IF) begin
          o_if_done = i_rdy && !i_if_cancel;
          o_if_inst = w_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= OWNER_NONE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_sign  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
    end else if (i_rdy) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept_mem) begin
            r_owner <= OWNER_MEM;
            r_cnt   <= '0;
            r_n     <= funct3_nbytes(i_mem_funct3);
            r_sign  <= !i_mem_funct3[2];
            r_we    <= i_mem_we;
            r_addr  <= i_mem_addr;
            r_wdata <= i_mem_wdata;
            r_data  <= '0;
          end else if (w_accept_if) begin
            r_owner <= OWNER_IF;
            r_cnt   <= '0;
            r_n     <= 3'd4;
            r_sign  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= i_if_addr;
            r_wdata <= '0;
            r_data  <= '0;
          end
        end
        ST_READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt != 3'd0) r_data[{w_cap_idx, 3'b000} +: 8] <= i_ram_din;
        end
        ST_WRITE:  r_cnt <= r_cnt + 3'd1;
        ST_FINISH: r_owner <= OWNER_NONE;
        default: ;
      endcase
      if (w_if_abort) r_owner <= OWNER_NONE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-wide RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        if_req, if_cancel, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr, busy;
  logic [7:0]  ram_dout, ram_din;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rdy        (rdy),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .i_if_cancel  (if_cancel),
    .o_if_done    (if_done),
    .o_if_inst    (if_inst),
    .i_mem_req    (mem_req),
    .i_mem_we     (mem_we),
    .i_mem_funct3 (mem_funct3),
    .i_mem_addr   (mem_addr),
    .i_mem_wdata  (mem_wdata),
    .o_mem_done   (mem_done),
    .o_mem_rdata  (mem_rdata),
    .o_ram_a      (ram_a),
    .o_ram_wr     (ram_wr),
    .o_ram_dout   (ram_dout),
    .i_ram_din    (ram_din),
    .o_busy       (busy)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  typedef struct {int unsigned cyc; logic [31:0] data; bit chkdata;} done_t;
  typedef struct {int unsigned cyc; logic [31:0] addr; bit wr; logic [7:0] dout;} bus_t;

  done_t       mem_q[$];
  done_t       if_q[$];
  bus_t        bus_q[$];
  int unsigned ncyc = 0;

  // RAM model: registered read, frozen by rdy; preloaded on the first edge.
  logic [7:0] ram [4096];
  bit         loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
      ram[12'h007] = 8'h80;
      ram[12'h010] = 8'h00; ram[12'h011] = 8'h80;
      ram[12'h200] = 8'hEF; ram[12'h201] = 8'hBE; ram[12'h202] = 8'hAD; ram[12'h203] = 8'hDE;
      ram[12'h000] = 8'h13; ram[12'h001] = 8'h05; ram[12'h002] = 8'h00; ram[12'h003] = 8'h00;
      ram[12'h040] = 8'hAA; ram[12'h041] = 8'hBB; ram[12'h042] = 8'hCC; ram[12'h043] = 8'hDD;
      ram[12'h080] = 8'h93; ram[12'h081] = 8'h00; ram[12'h082] = 8'h10; ram[12'h083] = 8'h00;
      ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22;
      loaded = 1'b1;
    end else if (rdy) begin
      if (ram_wr) ram[ram_a[11:0]] = ram_dout;
      ram_din <= ram[ram_a[11:0]];
    end
  end

  always @(negedge clk) begin
    bus_t  b;
    done_t d;
    ncyc++;
    if (bus_q.size() > 0 && bus_q[0].cyc == ncyc) begin
      b = bus_q.pop_front();
      chk("ram_a", ram_a, b.addr);
      chk("ram_wr", 32'(ram_wr), 32'(b.wr));
      if (b.wr) chk("ram_dout", 32'(ram_dout), 32'(b.dout));
    end else if (ram_wr) begin
      chk("spurious_wr", 32'(ram_wr), 32'd0);
    end
    if (!busy && ram_a != 32'd0) chk("idle_ram_a", ram_a, 32'd0);
    if (mem_done) begin
      if (mem_q.size() == 0) chk("spurious_mem_done", 32'(mem_done), 32'd0);
      else begin
        d = mem_q.pop_front();
        chk("mem_done_cyc", ncyc, d.cyc);
        if (d.chkdata) chk("mem_rdata", mem_rdata, d.data);
      end
    end
    if (if_done) begin
      if (if_q.size() == 0) chk("spurious_if_done", 32'(if_done), 32'd0);
      else begin
        d = if_q.pop_front();
        chk("if_done_cyc", ncyc, d.cyc);
        chk("if_inst", if_inst, d.data);
      end
    end
  end

  task automatic push_bus(input int unsigned base, input logic [31:0] a, input int unsigned n,
                          input bit we, input logic [31:0] wd);
    for (int unsigned k = 0; k < n; k++) begin
      logic [31:0] ak;
      ak = a + k;
      bus_q.push_back('{base + 1 + k, ak, we, wd[8*k +: 8]});
    end
  endtask

  task automatic start_mem(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int unsigned base);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = a; mem_wdata = wd;
    @(posedge clk); #1;
    base = ncyc;
  endtask

  task automatic wait_mem_done();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = mem_done;
    end
    if (!got) chk("mem_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic wait_if_done();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = if_done;
    end
    if (!got) chk("if_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic mem_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned n, input logic [31:0] exp);
    int unsigned base;
    start_mem(we, f3, a, wd, base);
    push_bus(base, a, n, we, wd);
    mem_q.push_back('{we ? base + n + 1 : base + n + 2, exp, !we});
    wait_mem_done();
  endtask

  task automatic fetch_op(input logic [31:0] a, input logic [31:0] exp);
    int unsigned base;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    @(posedge clk); #1;
    base = ncyc;
    push_bus(base, a, 4, 1'b0, 32'd0);
    if_q.push_back('{base + 6, exp, 1'b1});
    wait_if_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    rst_n = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_funct3 = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    rst_n = 1'b1;

    mem_op(1'b0, 3'b010, 32'h100, 32'd0, 4, 32'h12345678);
    mem_op(1'b0, 3'b000, 32'h7,   32'd0, 1, 32'hFFFFFF80);
    mem_op(1'b0, 3'b100, 32'h7,   32'd0, 1, 32'h00000080);
    mem_op(1'b0, 3'b001, 32'h10,  32'd0, 2, 32'hFFFF8000);
    mem_op(1'b0, 3'b101, 32'h10,  32'd0, 2, 32'h00008000);
    mem_op(1'b1, 3'b001, 32'h20,  32'hAABBCCDD, 2, 32'd0);
    mem_op(1'b0, 3'b101, 32'h20,  32'd0, 2, 32'h0000CCDD);

    // Simultaneous requests: MEM first, fetch after the IDLE gap.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_funct3 = 3'b010; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h0;
    @(posedge clk); #1;
    base = ncyc;
    push_bus(base, 32'h200, 4, 1'b0, 32'd0);
    push_bus(base + 7, 32'h0, 4, 1'b0, 32'd0);
    mem_q.push_back('{base + 6, 32'hDEADBEEF, 1'b1});
    if_q.push_back('{base + 13, 32'h00000513, 1'b1});
    wait_mem_done();
    wait_if_done();

    // Fetch cancelled in cycle 3 must not complete.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    @(posedge clk); #1;
    base = ncyc;
    push_bus(base, 32'h40, 3, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_cancel = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    if_cancel = 1'b0;
    chk("cancel_idle", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    fetch_op(32'h80, 32'h00100093);

    mem_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 4, 32'h05132211);

    // SW with rdy low in cycles 2-4.
    start_mem(1'b1, 3'b010, 32'h400, 32'h44332211, base);
    bus_q.push_back('{base + 1, 32'h400, 1'b1, 8'h11});
    bus_q.push_back('{base + 2, 32'h401, 1'b0, 8'h00});
    bus_q.push_back('{base + 3, 32'h401, 1'b0, 8'h00});
    bus_q.push_back('{base + 4, 32'h401, 1'b0, 8'h00});
    bus_q.push_back('{base + 5, 32'h401, 1'b1, 8'h22});
    bus_q.push_back('{base + 6, 32'h402, 1'b1, 8'h33});
    bus_q.push_back('{base + 7, 32'h403, 1'b1, 8'h44});
    mem_q.push_back('{base + 8, 32'd0, 1'b0});
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rdy = 1'b1;
    wait_mem_done();
    mem_op(1'b0, 3'b010, 32'h400, 32'd0, 4, 32'h44332211);

    // Reset pulsed in cycle 3 of an LW.
    start_mem(1'b0, 3'b010, 32'h100, 32'd0, base);
    push_bus(base, 32'h100, 2, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ram_a", ram_a, 32'd0);
    chk("mrst_ram_wr", 32'(ram_wr), 32'd0);
    chk("mrst_mem_done", 32'(mem_done), 32'd0);
    chk("mrst_mem_rdata", mem_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    mem_op(1'b0, 3'b010, 32'h100, 32'd0, 4, 32'h12345678);

    repeat (5) @(posedge clk);
    chk("mem_sb_left", mem_q.size(), 32'd0);
    chk("if_sb_left", if_q.size(), 32'd0);
    chk("bus_sb_left", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
